// File: rtl/gmsk_burst_feeder.sv
// rtl/gmsk_burst_feeder.sv - GMSK burst framer, differential encoder and strobe generator
module gmsk_burst_feeder #(
  parameter int SAMPLE_DIV         = 4,
  parameter int SAMPLES_PER_SYMBOL = 128,
  parameter int GUARD_SYMBOLS      = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  input  logic       byte_last,
  output logic       byte_ready,
  output logic       symbol_strobe,
  output logic       sample_strobe,
  output logic       tx_bit,
  output logic       burst_active,
  output logic       underrun
);

  localparam int CW   = $clog2(SAMPLE_DIV);
  localparam int SW   = (SAMPLES_PER_SYMBOL > 1) ? $clog2(SAMPLES_PER_SYMBOL) : 1;
  localparam int YMAX = (GUARD_SYMBOLS > 8) ? GUARD_SYMBOLS : 8;
  localparam int YW   = $clog2(YMAX);

  localparam logic [CW-1:0] CLK_LAST = CW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] CLK_SYM  = CW'(SAMPLE_DIV - 2);
  localparam logic [SW-1:0] SMP_LAST = SW'(SAMPLES_PER_SYMBOL - 1);
  localparam logic [YW-1:0] GRD_LAST = YW'(GUARD_SYMBOLS - 1);

  typedef enum logic [2:0] {IDLE, LEAD, DATA, TAIL, GUARD} state_t;

  state_t        state, state_n;
  logic [CW-1:0] clk_cnt, clk_n;
  logic [SW-1:0] sample_cnt, smp_n;
  logic [YW-1:0] sym_cnt, sym_n;
  logic [7:0]    hold_data, hold_n, shift, shift_n;
  logic          hold_full, hold_full_n, hold_last, hold_last_n;
  logic          shift_last, shift_last_n, last_accepted, last_acc_n;
  logic          prev_d, prev_n, prev_base, tx_n, active_n, under_n;
  logic          xfer, sym_end, load, tick, d_n;

  assign byte_ready = !reset && !hold_full && !last_accepted && state != TAIL && state != GUARD;
  assign xfer       = byte_valid && byte_ready;

  // Next-state: counters, symbol sequencing at symbol end, byte buffering and encoding at symbol start
  always_comb begin
    state_n      = state;
    sym_n        = sym_cnt;
    shift_n      = shift;
    shift_last_n = shift_last;
    hold_n       = hold_data;
    hold_full_n  = hold_full;
    hold_last_n  = hold_last;
    last_acc_n   = last_accepted;
    under_n      = underrun;
    active_n     = burst_active;
    prev_base    = prev_d;
    prev_n       = prev_d;
    tx_n         = tx_bit;
    load         = 1'b0;
    clk_n        = '0;
    smp_n        = '0;
    if (state != IDLE) begin
      clk_n = (clk_cnt == CLK_LAST) ? '0 : clk_cnt + 1'b1;
      smp_n = sample_cnt;
      if (clk_cnt == CLK_LAST) smp_n = (sample_cnt == SMP_LAST) ? '0 : sample_cnt + 1'b1;
    end
    // A symbol ends with its last sample; the next symbol's strobe follows SAMPLE_DIV-2 edges later
    sym_end = (state != IDLE) && (clk_cnt == CLK_LAST) && (sample_cnt == SMP_LAST);
    if (sym_end) begin
      sym_n = sym_cnt + 1'b1;
      case (state)
        LEAD: if (sym_cnt == YW'(2)) begin
          state_n = DATA;
          sym_n   = '0;
          load    = 1'b1;
        end
        DATA: begin
          shift_n = {1'b0, shift[7:1]};
          if (sym_cnt == YW'(7)) begin
            sym_n = '0;
            if (shift_last) begin
              state_n = TAIL;
            end else if (hold_full) begin
              load = 1'b1;
            end else begin
              under_n = 1'b1;
              state_n = TAIL;
            end
          end
        end
        TAIL: if (sym_cnt == YW'(2)) begin
          state_n = GUARD;
          sym_n   = '0;
        end
        GUARD: if (sym_cnt == GRD_LAST) begin
          state_n      = IDLE;
          sym_n        = '0;
          active_n     = 1'b0;
          last_acc_n   = 1'b0;
          shift_last_n = 1'b0;
          tx_n         = 1'b0;
        end
        default: ;
      endcase
    end
    if (load) begin
      shift_n      = hold_data;
      shift_last_n = hold_last;
      hold_full_n  = 1'b0;
    end
    if (xfer) begin
      hold_n      = byte_in;
      hold_full_n = 1'b1;
      hold_last_n = byte_last;
      if (byte_last) last_acc_n = 1'b1;
    end
    if (xfer && state == IDLE) begin
      state_n      = LEAD;
      sym_n        = '0;
      under_n      = 1'b0;
      prev_base    = 1'b1;
      prev_n       = 1'b1;
      active_n     = 1'b1;
      shift_last_n = 1'b0;
    end
    // With SAMPLE_DIV=2 the symbol start shares the edge with the symbol end, so use next values
    d_n  = (state_n == DATA) ? shift_n[0] : 1'b0;
    tick = (state_n != IDLE) && (clk_n == CLK_SYM) && (smp_n == '0);
    if (tick) begin
      tx_n   = d_n ^ prev_base;
      prev_n = d_n;
    end
  end

  // State and registered outputs, cleared asynchronously
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      clk_cnt       <= '0;
      sample_cnt    <= '0;
      sym_cnt       <= '0;
      hold_data     <= '0;
      hold_full     <= 1'b0;
      hold_last     <= 1'b0;
      shift         <= '0;
      shift_last    <= 1'b0;
      last_accepted <= 1'b0;
      prev_d        <= 1'b0;
      tx_bit        <= 1'b0;
      burst_active  <= 1'b0;
      underrun      <= 1'b0;
      symbol_strobe <= 1'b0;
      sample_strobe <= 1'b0;
    end else begin
      state         <= state_n;
      clk_cnt       <= clk_n;
      sample_cnt    <= smp_n;
      sym_cnt       <= sym_n;
      hold_data     <= hold_n;
      hold_full     <= hold_full_n;
      hold_last     <= hold_last_n;
      shift         <= shift_n;
      shift_last    <= shift_last_n;
      last_accepted <= last_acc_n;
      prev_d        <= prev_n;
      tx_bit        <= tx_n;
      burst_active  <= active_n;
      underrun      <= under_n;
      symbol_strobe <= tick;
      sample_strobe <= (state_n != IDLE) && (clk_n == CLK_LAST);
    end
  end

endmodule

// File: tb/tb_gmsk_burst_feeder.sv
// tb/tb_gmsk_burst_feeder.sv - self-checking bench for gmsk_burst_feeder
module tb_gmsk_burst_feeder;

  localparam int P     = 10;
  localparam int SPS   = 128;
  localparam int GS    = 8;
  localparam int DEPTH = 256;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] byte_in       [2];
  logic       byte_valid    [2];
  logic       byte_last     [2];
  logic       byte_ready    [2];
  logic       symbol_strobe [2];
  logic       sample_strobe [2];
  logic       tx_bit        [2];
  logic       burst_active  [2];
  logic       underrun      [2];

  int errors = 0;
  int checks = 0;

  int     nsym       [2];
  int     coinc      [2];
  int     und_rise   [2];
  int     und_sym    [2];
  bit     und_prev   [2];
  longint sym_t      [2][DEPTH];
  bit     rec        [2][DEPTH];
  int     samp_per   [2][DEPTH];
  longint samp_first [2][DEPTH];

  logic [7:0] pay [4];

  always #(P/2) clock = ~clock;

  gmsk_burst_feeder #(.SAMPLE_DIV(4), .SAMPLES_PER_SYMBOL(SPS), .GUARD_SYMBOLS(GS)) dut_a (
    .clock(clock), .reset(reset), .byte_in(byte_in[0]), .byte_valid(byte_valid[0]),
    .byte_last(byte_last[0]), .byte_ready(byte_ready[0]), .symbol_strobe(symbol_strobe[0]),
    .sample_strobe(sample_strobe[0]), .tx_bit(tx_bit[0]), .burst_active(burst_active[0]),
    .underrun(underrun[0])
  );

  gmsk_burst_feeder #(.SAMPLE_DIV(2), .SAMPLES_PER_SYMBOL(SPS), .GUARD_SYMBOLS(GS)) dut_b (
    .clock(clock), .reset(reset), .byte_in(byte_in[1]), .byte_valid(byte_valid[1]),
    .byte_last(byte_last[1]), .byte_ready(byte_ready[1]), .symbol_strobe(symbol_strobe[1]),
    .sample_strobe(sample_strobe[1]), .tx_bit(tx_bit[1]), .burst_active(burst_active[1]),
    .underrun(underrun[1])
  );

  // Record every symbol strobe (time, tx_bit), samples per symbol, strobe collisions and underrun rises
  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (symbol_strobe[i] === 1'b1 && sample_strobe[i] === 1'b1) coinc[i] <= coinc[i] + 1;
      if (symbol_strobe[i] === 1'b1) begin
        if (nsym[i] < DEPTH) begin
          sym_t[i][nsym[i]] <= $time;
          rec[i][nsym[i]]   <= tx_bit[i];
        end
        nsym[i] <= nsym[i] + 1;
      end
      if (sample_strobe[i] === 1'b1 && nsym[i] > 0 && nsym[i] <= DEPTH) begin
        if (samp_per[i][nsym[i]-1] == 0) samp_first[i][nsym[i]-1] <= $time;
        samp_per[i][nsym[i]-1] <= samp_per[i][nsym[i]-1] + 1;
      end
      if (underrun[i] === 1'b1 && !und_prev[i]) begin
        und_rise[i] <= und_rise[i] + 1;
        und_sym[i]  <= nsym[i];
      end
      und_prev[i] <= (underrun[i] === 1'b1);
    end
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] b, input logic last, input int budget,
                      output longint t);
    int k = 0;
    byte_in[i] = b;
    byte_last[i] = last;
    byte_valid[i] = 1'b1;
    t = -1;
    while (k < budget) begin
      if (byte_ready[i] === 1'b1) begin
        @(posedge clock);
        t = $time;
        #1;
        break;
      end
      @(negedge clock);
      k++;
    end
    if (t < 0) check("push_timeout", 0, 1);
  endtask

  task automatic wait_syms(input int i, input int target, input int budget);
    int k = 0;
    while (nsym[i] < target && k < budget) begin
      @(negedge clock);
      k++;
    end
    if (nsym[i] < target) check("sym_timeout", nsym[i], target);
  endtask

  task automatic wait_idle(input int i, input int budget);
    int k = 0;
    while (burst_active[i] === 1'b1 && k < budget) begin
      @(negedge clock);
      k++;
    end
    check("idle_reached", burst_active[i], 0);
  endtask

  // Expected symbols: 3 zero lead, payload bits LSB-first, 3 zero trail, GS zero guard; tx = d ^ previous d, starting from 1
  task automatic check_burst(input int i, input int base, input int cbase, input int nb, input string tag);
    bit     d [$];
    bit     prev = 1'b1;
    int     bad_tx = 0;
    int     bad_tm = 0;
    int     n = 6 + 8 * nb + GS;
    longint per = longint'((i == 0) ? 4 : 2) * SPS * P;
    repeat (3) d.push_back(1'b0);
    for (int b = 0; b < nb; b++)
      for (int j = 0; j < 8; j++) d.push_back(pay[b][j]);
    repeat (3 + GS) d.push_back(1'b0);
    check({tag, "_len"}, nsym[i] - base, n);
    for (int k = 0; k < d.size() && base + k < DEPTH; k++) begin
      if (rec[i][base+k] !== (d[k] ^ prev)) bad_tx++;
      prev = d[k];
    end
    check({tag, "_tx_bad"}, bad_tx, 0);
    for (int k = 0; k < n && base + k < DEPTH; k++) begin
      if (samp_per[i][base+k] != SPS) bad_tm++;
      if (samp_first[i][base+k] - sym_t[i][base+k] != P) bad_tm++;
      if (k > 0 && sym_t[i][base+k] - sym_t[i][base+k-1] != per) bad_tm++;
    end
    check({tag, "_timing_bad"}, bad_tm, 0);
    check({tag, "_coinc"}, coinc[i] - cbase, 0);
    check({tag, "_tx_idle"}, tx_bit[i], 0);
  endtask

  initial begin
    longint t0, t1, tf, t;
    int base, cb, ub, nb;
    logic [7:0] rb;
    for (int i = 0; i < 2; i++) begin
      byte_in[i] = 8'h00;
      byte_valid[i] = 1'b0;
      byte_last[i] = 1'b0;
    end
    #1 reset = 1'b1;
    #1;
    check("reset_out_a", {byte_ready[0], symbol_strobe[0], sample_strobe[0], tx_bit[0], burst_active[0], underrun[0]}, 0);
    check("reset_out_b", {byte_ready[1], symbol_strobe[1], sample_strobe[1], tx_bit[1], burst_active[1], underrun[1]}, 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1 check("ready_after_reset", byte_ready[0], 1);
    @(negedge clock);

    // Single byte 0xA5, then bytes offered during TAIL/GUARD
    base = nsym[0]; cb = coinc[0]; pay[0] = 8'hA5;
    push(0, 8'hA5, 1'b1, 20, t0);
    byte_valid[0] = 1'b0;
    wait_syms(0, base + 1, 20);
    check("lat_sym_a", sym_t[0][base] - t0, 2 * P + P / 2);
    wait_syms(0, base + 12, 13 * 600);
    byte_in[0] = 8'h00; byte_last[0] = 1'b0; byte_valid[0] = 1'b1;
    @(negedge clock);
    check("ready_tail", byte_ready[0], 0);
    wait_syms(0, base + 16, 6 * 600);
    check("ready_guard", byte_ready[0], 0);
    check("active_guard", burst_active[0], 1);
    wait_idle(0, 10 * 600);
    tf = $time;
    check("ready_idle", byte_ready[0], 1);
    check("lat_samp_a", samp_first[0][base] - t0, 3 * P + P / 2);
    check_burst(0, base, cb, 1, "a");
    check("a_under", underrun[0], 0);

    // Three bytes back-to-back, first taken in the first IDLE cycle
    base = nsym[0]; cb = coinc[0]; ub = und_rise[0];
    pay[0] = 8'h00; pay[1] = 8'hFF; pay[2] = 8'h0F;
    push(0, 8'h00, 1'b0, 4, t1);
    check("b2b_accept", t1 - tf, P / 2);
    push(0, 8'hFF, 1'b0, 3000, t);
    push(0, 8'h0F, 1'b1, 6000, t);
    byte_valid[0] = 1'b0;
    @(negedge clock);
    wait_idle(0, 40 * 600);
    check("lat_sym_b", sym_t[0][base] - t1, 2 * P + P / 2);
    check_burst(0, base, cb, 3, "b");
    check("b_under_rise", und_rise[0] - ub, 0);

    // Underrun: one byte without last
    @(negedge clock);
    base = nsym[0]; cb = coinc[0]; ub = und_rise[0]; pay[0] = 8'h3C;
    push(0, 8'h3C, 1'b0, 4, t);
    byte_valid[0] = 1'b0;
    @(negedge clock);
    wait_idle(0, 25 * 600);
    check_burst(0, base, cb, 1, "c");
    check("c_under_flag", underrun[0], 1);
    check("c_under_rise", und_rise[0] - ub, 1);
    check("c_under_at", und_sym[0] - base, 11);

    // Next burst clears underrun, then asynchronous reset mid-DATA
    @(negedge clock);
    base = nsym[0];
    rb = 8'($urandom);
    push(0, rb, 1'b1, 4, t);
    byte_valid[0] = 1'b0;
    check("under_clear", underrun[0], 0);
    wait_syms(0, base + 6, 8 * 600);
    check("active_before_reset", burst_active[0], 1);
    #2 reset = 1'b1;
    #1 check("reset_async", {byte_ready[0], symbol_strobe[0], sample_strobe[0], tx_bit[0], burst_active[0], underrun[0]}, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1 check("ready_after_abort", byte_ready[0], 1);
    @(negedge clock);
    base = nsym[0]; cb = coinc[0]; pay[0] = 8'h01;
    push(0, 8'h01, 1'b1, 4, t);
    byte_valid[0] = 1'b0;
    @(negedge clock);
    wait_idle(0, 25 * 600);
    check("lead_after_reset", int'({rec[0][base], rec[0][base+1], rec[0][base+2]}), 3'b100);
    check_burst(0, base, cb, 1, "d");

    // SAMPLE_DIV=2 instance with a random 1..3 byte burst
    @(negedge clock);
    base = nsym[1]; cb = coinc[1];
    nb = $urandom_range(1, 3);
    for (int b = 0; b < nb; b++) pay[b] = 8'($urandom);
    push(1, pay[0], 1'(nb == 1), 4, t1);
    for (int b = 1; b < nb; b++) push(1, pay[b], 1'(b == nb - 1), 3000, t);
    byte_valid[1] = 1'b0;
    @(negedge clock);
    wait_idle(1, 40 * 300);
    check("lat_sym_div2", sym_t[1][base] - t1, P / 2);
    check("lat_samp_div2", samp_first[1][base] - t1, P + P / 2);
    check_burst(1, base, cb, nb, "e");
    check("e_under", underrun[1], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
